// File: rtl/ubus_slave_mem.sv
// UBUS slave responder backed by a 2^MEM_AW-byte internal memory.
// Optional wait-state insertion is built only when UBUS_SLAVE_WAIT_EN is defined.
module ubus_slave_mem #(
   parameter logic [15:0] BASE_ADDR   = 16'h0000,
   parameter int          MEM_AW      = 8,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic        ubus_clock,
   input  logic        ubus_reset,
   input  logic        ubus_start,
   input  logic [15:0] ubus_addr,
   input  logic [1:0]  ubus_size,
   input  logic        ubus_read,
   input  logic        ubus_write,
   input  logic        ubus_bip,
   inout  wire  [7:0]  ubus_data,
   output logic        ubus_wait,
   output logic        ubus_error
);

   // state | meaning
   // IDLE  | waiting for an arbitration-phase start
   // ADDR  | address phase, decode window and direction
   // DATA  | selected, completing data beats
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t            state_q;
   logic              rd_q;
   logic [MEM_AW-1:0] ptr_q;
   logic [3:0]        beats_q;
   logic [7:0]        mem_q [2**MEM_AW];

   logic [16:0] offset;
   logic        in_window;
   logic        addr_ok;
   logic        selected;
   logic        wait_active;
   logic        last;
   logic        err;
   logic        beat;

   // 17-bit difference so addresses below BASE_ADDR fall outside the window
   assign offset    = {1'b0, ubus_addr} - {1'b0, BASE_ADDR};
   assign in_window = offset < 17'(2**MEM_AW);
   assign addr_ok   = in_window && (ubus_read ^ ubus_write);

   assign selected = (state_q == DATA);
   assign last     = (beats_q == 4'd1);
   assign err      = selected && !wait_active && (ubus_bip == last);
   assign beat     = selected && !wait_active && !err;

`ifdef UBUS_SLAVE_WAIT_EN
   logic [3:0] wait_cnt_q;

   assign wait_active = (wait_cnt_q != 4'd0);

   always_ff @(posedge ubus_clock or posedge ubus_reset) begin
      if (ubus_reset) begin
         wait_cnt_q <= 4'd0;
      end else if (state_q == ADDR && addr_ok) begin
         wait_cnt_q <= 4'(WAIT_CYCLES);
      end else if (selected) begin
         if (wait_active) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
         end else if (beat) begin
            wait_cnt_q <= 4'(WAIT_CYCLES);
         end
      end
   end
`else
   logic [3:0] unused_wait_cfg;

   assign unused_wait_cfg = 4'(WAIT_CYCLES);
   assign wait_active     = 1'b0;
`endif

   always_ff @(posedge ubus_clock or posedge ubus_reset) begin
      if (ubus_reset) begin
         state_q <= IDLE;
         rd_q    <= 1'b0;
         ptr_q   <= '0;
         beats_q <= 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ubus_start) begin
                  state_q <= ADDR;
               end
            end
            ADDR: begin
               if (addr_ok) begin
                  state_q <= DATA;
                  rd_q    <= ubus_read;
                  ptr_q   <= offset[MEM_AW-1:0];
                  beats_q <= 4'd1 << ubus_size;
               end else begin
                  state_q <= IDLE;
               end
            end
            DATA: begin
               if (err) begin
                  state_q <= IDLE;
               end else if (beat) begin
                  ptr_q   <= ptr_q + 1'b1;
                  beats_q <= beats_q - 4'd1;
                  if (last) begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Memory is deliberately not reset
   always_ff @(posedge ubus_clock) begin
      if (beat && !rd_q) begin
         mem_q[ptr_q] <= ubus_data;
      end
   end

   assign ubus_data  = (selected && rd_q && !wait_active) ? mem_q[ptr_q] : 8'bzzzzzzzz;
   assign ubus_wait  = selected ? wait_active : 1'bz;
   assign ubus_error = selected ? err : 1'bz;

endmodule

// File: doc/ubus_slave_mem.md
# ubus_slave_mem

UBUS slave responder backed by a 2^MEM_AW-byte internal memory. It decodes UBUS transfers addressed to its window and completes read and write data phases. It inserts optional wait states and flags protocol errors on the shared bus. It sits on the UBUS alongside the arbiter and the masters, and is the responder end of every granted transfer into its window.

## Interface
- BASE_ADDR, 16'h0000: first byte address of the slave window.
- MEM_AW, 8: memory address width; the window spans 2^MEM_AW bytes, BASE_ADDR to BASE_ADDR+2^MEM_AW-1.
- WAIT_CYCLES, 0: wait states inserted before each data beat, range 0–15; only honoured with UBUS_SLAVE_WAIT_EN.
- ubus_clock  input  1  bus clock; all state changes on the rising edge.
- ubus_reset  input  1  asynchronous, active-high reset.
- ubus_start  input  1  arbitration-phase marker from the arbiter.
- ubus_addr  input  16  byte address, valid in the address phase.
- ubus_size  input  2  beat count code: 0→1, 1→2, 2→4, 3→8 beats.
- ubus_read  input  1  read request, valid in the address phase.
- ubus_write  input  1  write request, valid in the address phase.
- ubus_bip  input  1  burst in progress; the master holds it high on every beat except the last.
- ubus_data  inout  8  data bus; the slave drives it only on read beats while selected.
- ubus_wait  output  1  slave wait; high-Z when not selected.
- ubus_error  output  1  slave error; high-Z when not selected.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE → ADDR: on any posedge that samples ubus_start=1.
- ADDR → DATA: on the next posedge, when all hold:
  - ubus_addr is inside the window;
  - exactly one of ubus_read or ubus_write is 1.
- At that ADDR → DATA edge:
  - latch direction;
  - load ptr = (ubus_addr-BASE_ADDR) mod 2^MEM_AW;
  - load beats = 1<<ubus_size;
  - load wait_cnt = WAIT_CYCLES.
- ADDR → IDLE otherwise. This covers no-op address phases (read=write=0), read=write=1, and out-of-window addresses. Nothing is driven.
- Selected means state DATA. While selected, ubus_wait and ubus_error are driven 0/1. Otherwise both are high-Z.
- ubus_wait = (wait_cnt != 0). wait_cnt decrements by 1 each cycle while nonzero.
- A beat completes at a posedge where ubus_wait=0 and ubus_error=0.
  - Write beat: mem[ptr] <= ubus_data.
  - Read beat: ubus_data is driven with mem[ptr] for the whole DATA cycle when wait=0.
  - After any completed beat: ptr increments mod 2^MEM_AW, so the burst wraps inside the window; beats decrements; wait_cnt reloads WAIT_CYCLES.
- last = (beats==1).
- ubus_error is combinational: DATA && !ubus_wait && (ubus_bip == last).
  - bip=1 on the last beat is an overrun; bip=0 before the last beat is an early end.
  - On error the beat's write is discarded and the FSM returns to IDLE at that edge.
- DATA → IDLE: when the last beat completes with bip=0.
- ubus_start=1 sampled while in DATA is ignored; the arbiter does not restart before the transfer ends.
- Memory contents are not reset and are undefined after power-up.

## Timing
- Reset (asynchronous, active-high):
  - state=IDLE, wait_cnt=0, beats=0, ptr=0;
  - ubus_wait, ubus_error and ubus_data go high-Z immediately.
- Reset asserted mid-transfer aborts the transfer. An in-flight write beat not yet clocked is lost.
- Cycle n samples start=1. Cycle n+1 is the address phase. Cycle n+2 is the first data cycle.
- Zero-wait read: data is valid in cycle n+2.
- Each beat occupies WAIT_CYCLES+1 cycles.
- Total data phase = beats × (WAIT_CYCLES+1) cycles.
- The read drive enable follows the state register, so data is released (high-Z) in the cycle after the last beat.

## Configuration
- UBUS_SLAVE_WAIT_EN defined: wait_cnt logic is present and WAIT_CYCLES wait states precede every beat.
- UBUS_SLAVE_WAIT_EN undefined:
  - wait_cnt is not built and WAIT_CYCLES is ignored;
  - ubus_wait is 0 whenever selected;
  - every DATA cycle is a beat.

## Test plan
- Single write: BASE_ADDR=16'h1000, write 16'h1005, size=0, data 8'hA5, bip=0. Response: one DATA cycle, wait=0, error=0; a later read of 16'h1005 returns 8'hA5 in cycle n+2.
- 4-beat read, WAIT_CYCLES=2 with macro defined: from 16'h1010, preloaded 8'h01–04. Response: wait=1 for 2 cycles before each beat; data 01,02,03,04 each valid one cycle; 12 data cycles total; then high-Z.
- Window wrap: MEM_AW=8, 8-beat write at 16'h10FC of 8'h10–17. Response: bytes land at offsets FC–FF then 00–03; reads confirm.
- Decode miss and no-op: address 16'h2000, or read=write=0. Response: FSM returns to IDLE after the address phase; wait, error and data stay high-Z; memory unchanged.
- Protocol errors:
  - size=1 write with bip=0 on beat 1 → error=1 that cycle, no write, FSM to IDLE.
  - size=0 with bip=1 → error=1.
- Reset mid-burst: reset asserted on beat 2 of 4 → outputs go high-Z asynchronously, state IDLE; the next start, address and data transfer completes normally.
